// File: rtl/turno_multi.sv
// Turn controller: rotates the active player on a move or, with TURNO_TIMER_EN
// defined, on a per-turn timeout, declaring a forfeit after MAX_STRIKES consecutive timeouts.
module turno_multi #(
    parameter int PLAYERS        = 2,
    parameter int TIMEOUT_CYCLES = 250,
    parameter int MAX_STRIKES    = 3,
    parameter int FIRST_PLAYER   = 0,
    localparam int PW = (PLAYERS > 1) ? $clog2(PLAYERS) : 1,
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               jugado,
    output logic [PW-1:0]      turno,
    output logic [PLAYERS-1:0] turno_oh,
    output logic [TW-1:0]      tiempo_rest,
    output logic               tiempo_fin,
    output logic               abandono,
    output logic [PW-1:0]      perdedor,
    output logic               estado_dbg
);

    if (PLAYERS < 2) begin : g_chk_players
        $error("turno_multi: PLAYERS must be at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
        $error("turno_multi: TIMEOUT_CYCLES must be at least 2");
    end
    if (MAX_STRIKES < 1) begin : g_chk_strikes
        $error("turno_multi: MAX_STRIKES must be at least 1");
    end
    if (FIRST_PLAYER < 0 || FIRST_PLAYER >= PLAYERS) begin : g_chk_first
        $error("turno_multi: FIRST_PLAYER out of range");
    end

    localparam logic [PW-1:0]      TURNO_INI = PW'(FIRST_PLAYER);
    localparam logic [PLAYERS-1:0] OH_INI    = PLAYERS'(1) << FIRST_PLAYER;

    // Next player in rotation; the one-hot copy rotates left in lockstep.
    logic [PW-1:0]      turno_sig;
    logic [PLAYERS-1:0] oh_sig;

    assign turno_sig = (turno == PW'(PLAYERS - 1)) ? '0 : turno + 1'b1;
    assign oh_sig    = {turno_oh[PLAYERS-2:0], turno_oh[PLAYERS-1]};

`ifdef TURNO_TIMER_EN

    localparam int SW = $clog2(MAX_STRIKES + 1);

    typedef enum logic {
        JUGANDO = 1'b0,
        FIN     = 1'b1
    } estado_t;

    estado_t       estado;
    logic [SW-1:0] strikes [PLAYERS];

    assign estado_dbg = (estado == FIN);

    // jugado has priority over expiry; FIN only leaves through reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            estado      <= JUGANDO;
            turno       <= TURNO_INI;
            turno_oh    <= OH_INI;
            tiempo_rest <= TW'(TIMEOUT_CYCLES);
            tiempo_fin  <= 1'b0;
            abandono    <= 1'b0;
            perdedor    <= '0;
            for (int i = 0; i < PLAYERS; i++) begin
                strikes[i] <= '0;
            end
        end else begin
            tiempo_fin <= 1'b0;
            case (estado)
                JUGANDO: begin
                    if (en) begin
                        if (jugado) begin
                            strikes[turno] <= '0;
                            turno          <= turno_sig;
                            turno_oh       <= oh_sig;
                            tiempo_rest    <= TW'(TIMEOUT_CYCLES);
                        end else if (tiempo_rest > TW'(1)) begin
                            tiempo_rest <= tiempo_rest - 1'b1;
                        end else if (strikes[turno] == SW'(MAX_STRIKES - 1)) begin
                            // Final strike: freeze turn and timer, record the loser.
                            strikes[turno] <= strikes[turno] + 1'b1;
                            estado         <= FIN;
                            abandono       <= 1'b1;
                            perdedor       <= turno;
                        end else begin
                            strikes[turno] <= strikes[turno] + 1'b1;
                            turno          <= turno_sig;
                            turno_oh       <= oh_sig;
                            tiempo_rest    <= TW'(TIMEOUT_CYCLES);
                            tiempo_fin     <= 1'b1;
                        end
                    end
                end
                FIN: begin
                end
                default: estado <= JUGANDO;
            endcase
        end
    end

`else

    assign tiempo_rest = '0;
    assign tiempo_fin  = 1'b0;
    assign abandono    = 1'b0;
    assign perdedor    = '0;
    assign estado_dbg  = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            turno    <= TURNO_INI;
            turno_oh <= OH_INI;
        end else if (en && jugado) begin
            turno    <= turno_sig;
            turno_oh <= oh_sig;
        end
    end

`endif

endmodule

// File: doc/turno_multi.md
# turno_multi

Parametrised turn controller for the TicTacToe game logic. Rotates the active turn among `PLAYERS` players and advances on a placed move or on a per-turn timeout. Tracks consecutive timeouts per player and declares a forfeit after `MAX_STRIKES` of them. It sits between the board/move-detection logic, which drives `jugado`, and the display and board-write logic, which consume `turno`.

## Interface
- `PLAYERS`, default 2: number of players, minimum 2. `PW = max(1, $clog2(PLAYERS))`.
- `TIMEOUT_CYCLES`, default 250: enabled cycles allowed per turn, minimum 2. `TW = $clog2(TIMEOUT_CYCLES+1)`.
- `MAX_STRIKES`, default 3: consecutive timeouts by one player that trigger a forfeit, minimum 1.
- `FIRST_PLAYER`, default 0: player index loaded at reset. Must be < `PLAYERS`.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `en`, in, 1: run/pause. While 0, the timer holds and `jugado` is ignored.
- `jugado`, in, 1: the current player placed an X/O. One-cycle pulse.
- `turno`, out, PW: index of the current player.
- `turno_oh`, out, PLAYERS: one-hot copy of `turno`.
- `tiempo_rest`, out, TW: enabled cycles left in the current turn.
- `tiempo_fin`, out, 1: one-cycle pulse marking the turn change caused by a timeout.
- `abandono`, out, 1: forfeit flag. Sticky until reset.
- `perdedor`, out, PW: index of the forfeiting player. Valid while `abandono`=1.

## Operation
- Two states:
  - `JUGANDO`: normal play.
  - `FIN`: forfeit declared; terminal until reset.
- Reset values, applied on the edge where `rst`=0:
  - state `JUGANDO`, `turno`=`FIRST_PLAYER`, `turno_oh`=1<<`FIRST_PLAYER`.
  - `tiempo_rest`=`TIMEOUT_CYCLES`.
  - `tiempo_fin`=0, `abandono`=0, `perdedor`=0.
  - all strike counters 0.
- In `JUGANDO` with `en`=1:
  - On `jugado`=1:
    - `turno` advances to `(turno+1) mod PLAYERS`, wrapping from PLAYERS-1 to 0.
    - `tiempo_rest` reloads to `TIMEOUT_CYCLES`.
    - The strike counter of the player who moved clears to 0.
  - With no `jugado` and `tiempo_rest`>1: `tiempo_rest` decrements by 1.
  - With no `jugado` and `tiempo_rest`=1, the turn expires:
    - The current player's strike counter increments.
    - If the new count equals `MAX_STRIKES`: go to `FIN`, `abandono`=1, `perdedor`=`turno`. `turno` is frozen and the timer stops.
    - Otherwise: `turno` advances, `tiempo_rest` reloads, `tiempo_fin` pulses.
- Simultaneous `jugado` and expiry: `jugado` wins. There is no timeout, no strike, and no `tiempo_fin`.
- In `JUGANDO` with `en`=0: all state holds and `jugado` is dropped. Pauses are not counted.
- In `FIN`: every input except `rst` is ignored. Outputs hold, with `tiempo_fin`=0.
- Strike counters are per player and `$clog2(MAX_STRIKES+1)` bits wide. They never exceed `MAX_STRIKES`.

## Timing
- All outputs are registered. `turno`, `turno_oh`, `tiempo_rest`, `abandono` and `perdedor` change on the edge that samples the cause, so they are visible one cycle after the input is asserted.
- A turn with no move lasts exactly `TIMEOUT_CYCLES` enabled cycles. `tiempo_rest` steps T, T-1, …, 1, then reloads.
- `tiempo_fin` is high for exactly one cycle, coincident with the first cycle of the new turn.
- `jugado` held high for k enabled cycles advances k turns. A single advance requires a pulse.
- Reset mid-turn or in `FIN` restores all reset values on the next edge, with no residual strikes.

## Configuration
- Macro: `TURNO_TIMER_EN`.
- Defined: timer, strike counters, `FIN` state, `tiempo_fin`, `abandono` and `perdedor` behave as described above.
- Undefined:
  - No timer or strike logic is synthesised.
  - `tiempo_rest`, `tiempo_fin`, `abandono` and `perdedor` are tied to 0.
  - `turno` advances only on `jugado`, gated by `en`.
  - `TIMEOUT_CYCLES` and `MAX_STRIKES` are unused.

## Test plan
- Reset, then pulse `jugado` 4 times with PLAYERS=3 and `en`=1 -> `turno` sequence 0,1,2,0,1. `turno_oh` matches at every step.
- TIMEOUT_CYCLES=5, no moves -> `tiempo_rest` 5,4,3,2,1, then `tiempo_fin`=1 for one cycle, `turno`=1 and `tiempo_rest`=5.
- `jugado` on the cycle where `tiempo_rest`=1 -> `turno` advances, `tiempo_fin` stays 0, and the mover's strike count is 0.
- MAX_STRIKES=2, PLAYERS=2, no moves -> P0 timeout, P1 timeout, then P0 timeout a second time -> `abandono`=1, `perdedor`=0. After that, `turno` is frozen and further `jugado` is ignored.
- `en`=0 for 10 cycles mid-turn with `tiempo_rest`=3 and `jugado` pulsed during the pause -> `tiempo_rest` holds at 3 and `turno` is unchanged. Countdown resumes when `en`=1.
- `rst`=0 for one cycle while in `FIN` -> `abandono`=0, `turno`=`FIRST_PLAYER`, `tiempo_rest`=`TIMEOUT_CYCLES`. With `TURNO_TIMER_EN` undefined, rerun the first scenario and confirm `tiempo_fin` is never asserted.
